// File: rtl/gpi_debounce.sv
// -----------------------------------------------------------------------------
// gpi_debounce
//
// Purpose:
//   Per-bit synchroniser and debouncer for raw board switch/button inputs.
//   Each bit is passed through a SyncStages-deep flop chain to remove
//   metastability. A new level is accepted only after the synchronised input
//   has disagreed with the current debounced level for DebounceCycles
//   consecutive cycles. Every accepted change produces a one-cycle rise or
//   fall pulse in the same cycle the debounced level changes.
//
// Optional feature (macro GPI_DEBOUNCE_STICKY_IRQ_EN):
//   When defined, each bit has a sticky edge flag. The flag is set by
//   rise_o|fall_o and cleared by a 1 on the matching irq_clr_i bit; set wins
//   over clear. irq_o is the registered OR of all flags. When the macro is
//   undefined, no flags exist, irq_clr_i is ignored and irq_o is 0.
//
// Handshake:
//   There is no valid/ready interface. gp_raw_i is sampled on every clock edge
//   and gp_o/rise_o/fall_o/irq_o are valid on every cycle outside reset.
//
// Ports:
//   clk_sys_i  in   1      system clock
//   rst_sys_i  in   1      synchronous, active-high reset
//   gp_raw_i   in   Width  asynchronous raw pad inputs
//   gp_o       out  Width  debounced level
//   rise_o     out  Width  one-cycle pulse when a gp_o bit goes 0->1
//   fall_o     out  Width  one-cycle pulse when a gp_o bit goes 1->0
//   irq_clr_i  in   Width  write-1-to-clear for the sticky edge flags
//   irq_o      out  1      OR of the sticky edge flags
//   dbg_state  out  Width  per-bit FSM state (0 = STABLE, 1 = CHANGING)
// -----------------------------------------------------------------------------
module gpi_debounce #(
  parameter int Width          = 8,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 50000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  input  logic [Width-1:0] irq_clr_i,
  output logic             irq_o,
  output logic [Width-1:0] dbg_state
);

  // Counter only has to reach DebounceCycles-1; the +1 keeps the width
  // non-zero for DebounceCycles == 1.
  localparam int CntW = (DebounceCycles < 1) ? 1 : $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (SyncStages < 2 || SyncStages > 4) begin : g_bad_sync_stages
    $error("gpi_debounce: SyncStages must be in 2..4");
  end

  if (DebounceCycles < 1) begin : g_bad_debounce_cycles
    $error("gpi_debounce: DebounceCycles must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser chain: plain flop-to-flop, no logic between stages.
  // ---------------------------------------------------------------------------
  logic [Width-1:0] sync_q [SyncStages];
  logic [Width-1:0] sync_last;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gp_raw_i;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_last = sync_q[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Per-bit debounce FSM.
  // The two states {STABLE, CHANGING} are not stored separately: a bit is
  // CHANGING whenever its counter is non-zero or its synchronised input
  // disagrees with the debounced level.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } state_e;

  logic [Width-1:0] level_q;
  logic [Width-1:0] level_d;
  logic [Width-1:0] rise_q;
  logic [Width-1:0] rise_d;
  logic [Width-1:0] fall_q;
  logic [Width-1:0] fall_d;
  logic [Width-1:0] mismatch;
  logic [Width-1:0] accept;
  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];
  state_e           state [Width];

  assign mismatch = sync_last ^ level_q;

  // State register
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int b = 0; b < Width; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int b = 0; b < Width; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  // Next-state logic. Any cycle without a mismatch drops the count back to 0,
  // so bounce always restarts the qualification window. The counter saturates
  // by construction: reaching CntLast with a mismatch accepts and clears.
  always_comb begin
    accept = '0;
    for (int b = 0; b < Width; b++) begin
      cnt_d[b] = '0;
      if (mismatch[b]) begin
        if (cnt_q[b] == CntLast) begin
          accept[b] = 1'b1;
        end else begin
          cnt_d[b] = cnt_q[b] + CntW'(1);
        end
      end
    end
    level_d = level_q ^ accept;
    // Pulses are registered alongside level_q so they line up with gp_o.
    rise_d  = accept & sync_last;
    fall_d  = accept & ~sync_last;
  end

  // Output logic
  always_comb begin
    dbg_state = '0;
    for (int b = 0; b < Width; b++) begin
      state[b]     = (mismatch[b] || (cnt_q[b] != '0)) ? ST_CHANGING : ST_STABLE;
      dbg_state[b] = (state[b] == ST_CHANGING);
    end
  end

  assign gp_o   = level_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

  // ---------------------------------------------------------------------------
  // Sticky edge flags / interrupt
  // ---------------------------------------------------------------------------
`ifdef GPI_DEBOUNCE_STICKY_IRQ_EN
  logic [Width-1:0] flag_q;
  logic [Width-1:0] flag_d;
  logic             irq_q;

  // Flags are fed from the registered pulses, so irq_o follows rise_o/fall_o
  // by one cycle. OR-ing the set term after the clear mask makes set win.
  assign flag_d = (flag_q & ~irq_clr_i) | rise_q | fall_q;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      irq_q  <= |flag_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// -----------------------------------------------------------------------------
// tb_gpi_debounce
//
// Bench for gpi_debounce with Width=8, SyncStages=2, DebounceCycles=4.
// The reference model records every sampled input and reset value and decides
// acceptance from a sliding window: a bit changes at edge t exactly when the
// synchronised value seen at each of the last DebounceCycles edges (none of
// them a reset edge) differs from the current debounced level. Expected
// outputs are pushed to exp_q at each posedge and compared at the following
// negedge. Directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_gpi_debounce;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int MAXC = 2048;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gp_raw;
  logic [W-1:0] irq_clr;
  logic [W-1:0] gp_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic         irq_o;
  logic [W-1:0] dbg_state;

  always #5 clk = ~clk;

  gpi_debounce #(
    .Width          (W),
    .SyncStages     (S),
    .DebounceCycles (D)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .gp_raw_i  (gp_raw),
    .gp_o      (gp_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .irq_clr_i (irq_clr),
    .irq_o     (irq_o),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [3*W:0] exp_q[$];   // {irq, gp, rise, fall}

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] raw_h [MAXC];
  bit           rst_h [MAXC];
  int           cyc = 0;
  logic [W-1:0] level_m = '0;
  logic [W-1:0] rise_m  = '0;
  logic [W-1:0] fall_m  = '0;
  logic [W-1:0] flag_m  = '0;
  logic         irq_m   = 1'b0;
  bit           overflow_seen = 1'b0;

  // Synchronised value visible just before edge u: the raw sample from edge
  // u-S, unless a reset edge fell anywhere in u-S..u-1.
  function automatic logic [W-1:0] sync_seen(input int u);
    if (u - S < 0) return '0;
    for (int e = u - S; e <= u - 1; e++) begin
      if (rst_h[e]) return '0;
    end
    return raw_h[u-S];
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] acc;
    logic [W-1:0] s;
    logic [W-1:0] prev_pulse;
    bit           ok;
    int           e;
    if (cyc >= MAXC) begin
      if (!overflow_seen) begin
        overflow_seen = 1'b1;
        checks++;
        errors++;
        $display("FAIL model_budget: got cycle %0d expected below %0d", cyc, MAXC);
      end
    end else begin
      raw_h[cyc] = gp_raw;
      rst_h[cyc] = rst;
      prev_pulse = rise_m | fall_m;
      if (rst) begin
        level_m = '0;
        rise_m  = '0;
        fall_m  = '0;
        flag_m  = '0;
        irq_m   = 1'b0;
      end else begin
        acc = '0;
        for (int b = 0; b < W; b++) begin
          ok = 1'b1;
          for (int j = 0; j < D; j++) begin
            e = cyc - j;
            if (e < 0 || rst_h[e]) begin
              ok = 1'b0;
            end else begin
              s = sync_seen(e);
              if (s[b] == level_m[b]) ok = 1'b0;
            end
          end
          acc[b] = ok;
        end
        rise_m  = acc & ~level_m;
        fall_m  = acc & level_m;
        level_m = level_m ^ acc;
`ifdef GPI_DEBOUNCE_STICKY_IRQ_EN
        flag_m  = (flag_m & ~irq_clr) | prev_pulse;
        irq_m   = |flag_m;
`else
        irq_m   = 1'b0;
`endif
      end
      exp_q.push_back({irq_m, level_m, rise_m, fall_m});
      cyc++;
    end
  end

  // Compare process: one model entry per edge, checked half a cycle later.
  always @(negedge clk) begin
    logic [3*W:0] ex;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      check("model_gp",   gp_o,   ex[3*W-1:2*W]);
      check("model_rise", rise_o, ex[2*W-1:W]);
      check("model_fall", fall_o, ex[W-1:0]);
      check("model_irq",  {{(W-1){1'b0}}, irq_o}, {{(W-1){1'b0}}, ex[3*W]});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic [W-1:0] seen;   // OR of gp_o|rise_o|fall_o over a window

  task automatic tick();
    @(negedge clk);
    seen = seen | gp_o | rise_o | fall_o;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [5:0] bounce;
    bounce  = 6'b101101;   // bit i = level at edge k+i: 1,0,1,1,0,1
    rst     = 1'b1;
    gp_raw  = 8'hFF;
    irq_clr = '0;
    seen    = '0;

    // Reset held with all inputs high.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_gp",   gp_o,   8'h00);
      check("rst_rise", rise_o, 8'h00);
      check("rst_fall", fall_o, 8'h00);
    end
    check("rst_irq", {7'b0, irq_o}, 8'h00);
    rst = 1'b0;                 // next edge is the first non-reset edge e1
    settle(5);                  // after e5
    check("rst_rel_early", gp_o, 8'h00);
    tick();                     // after e6
    check("rst_rel_gp",   gp_o,   8'hFF);
    check("rst_rel_rise", rise_o, 8'hFF);
    tick();
    check("rst_rel_rise_end", rise_o, 8'h00);
    check("rst_rel_hold",     gp_o,   8'hFF);

    gp_raw = 8'h00;
    settle(10);
    check("settle_zero", gp_o, 8'h00);
    check("settle_dbg",  dbg_state, 8'h00);

    // Clean rising edge on bit 0, sampled at edge k.
    gp_raw = 8'h01;
    settle(5);                  // after k+4
    check("edge0_early", gp_o, 8'h00);
    check("edge0_dbg",   dbg_state, 8'h01);
    tick();                     // after k+5
    check("edge0_gp",   gp_o,   8'h01);
    check("edge0_rise", rise_o, 8'h01);
    check("edge0_fall", fall_o, 8'h00);
    check("edge0_dbg_done", dbg_state, 8'h00);
    tick();
    check("edge0_rise_end", rise_o, 8'h00);

    // Reverse edge.
    gp_raw = 8'h00;
    settle(5);
    check("fall0_early", gp_o, 8'h01);
    tick();
    check("fall0_gp",   gp_o,   8'h00);
    check("fall0_fall", fall_o, 8'h01);
    check("fall0_rise", rise_o, 8'h00);
    tick();
    check("fall0_fall_end", fall_o, 8'h00);
    settle(4);

    // Glitch on bit 3 lasting one cycle fewer than the window.
    seen   = '0;
    gp_raw = 8'h08;
    settle(3);
    gp_raw = 8'h00;
    settle(12);
    check("glitch3_quiet", seen, 8'h00);

    // Bit 3 high for exactly the window length: accepted, then released.
    gp_raw = 8'h08;
    settle(4);                  // after k+3
    gp_raw = 8'h00;             // low sampled at k+4
    tick();
    check("glitch4_early", gp_o, 8'h00);
    tick();                     // after k+5
    check("glitch4_gp",   gp_o,   8'h08);
    check("glitch4_rise", rise_o, 8'h08);
    settle(3);                  // after k+8
    check("glitch4_hold", gp_o, 8'h08);
    tick();                     // after k+9
    check("glitch4_gp_low", gp_o,   8'h00);
    check("glitch4_fall",   fall_o, 8'h08);
    settle(4);

    // Bounce on bit 5, final transition sampled at edge k+5.
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      gp_raw = bounce[i] ? 8'h20 : 8'h00;
      tick();
    end
    gp_raw = 8'h20;
    settle(4);                  // after k+9
    check("bounce_quiet", seen, 8'h00);
    tick();                     // after k+10
    check("bounce_rise", rise_o, 8'h20);
    check("bounce_gp",   gp_o,   8'h20);
    check("bounce_fall", fall_o, 8'h00);
    tick();
    check("bounce_rise_end", rise_o, 8'h00);
    gp_raw = 8'h00;
    settle(8);

    // Simultaneous changes on several bits.
    gp_raw = 8'hC3;
    settle(5);
    check("multi_early", rise_o, 8'h00);
    tick();
    check("multi_rise", rise_o, 8'hC3);
    check("multi_gp",   gp_o,   8'hC3);
    gp_raw = 8'h00;
    settle(5);
    tick();
    check("multi_fall", fall_o, 8'hC3);
    settle(4);

    // Reset while bit 2 is mid-count (counter at 2 after edge k+3).
    seen   = '0;
    gp_raw = 8'h04;
    settle(4);                  // after k+3
    rst = 1'b1;                 // reset edge k+4
    tick();
    rst = 1'b0;                 // first non-reset edge e1 = k+5
    settle(5);                  // after e5
    check("midrst_quiet", seen, 8'h00);
    tick();                     // after e6
    check("midrst_gp",   gp_o,   8'h04);
    check("midrst_rise", rise_o, 8'h04);
    gp_raw = 8'h00;
    settle(8);

`ifdef GPI_DEBOUNCE_STICKY_IRQ_EN
    irq_clr = 8'hFF;
    tick();
    irq_clr = 8'h00;
    tick();
    check("irq_cleared", {7'b0, irq_o}, 8'h00);

    // Rise on bit 1: irq follows rise_o by one cycle.
    gp_raw = 8'h02;
    settle(6);                  // after k+5
    check("irq_rise1",  rise_o, 8'h02);
    check("irq_before", {7'b0, irq_o}, 8'h00);
    tick();
    check("irq_set", {7'b0, irq_o}, 8'h01);
    irq_clr = 8'h02;
    tick();
    irq_clr = 8'h00;
    check("irq_clr", {7'b0, irq_o}, 8'h00);
    tick();
    check("irq_clr_hold", {7'b0, irq_o}, 8'h00);

    // Clear coincident with a new edge on bit 1: set wins.
    gp_raw = 8'h00;
    settle(6);                  // after k'+5
    check("irq_fall1", fall_o, 8'h02);
    irq_clr = 8'h02;
    tick();
    irq_clr = 8'h00;
    check("irq_set_wins", {7'b0, irq_o}, 8'h01);
    tick();
    check("irq_set_wins_hold", {7'b0, irq_o}, 8'h01);
    irq_clr = 8'h02;
    tick();
    irq_clr = 8'h00;
    tick();
    check("irq_final_clr", {7'b0, irq_o}, 8'h00);
`else
    // Without sticky flags the clear input must have no effect.
    gp_raw  = 8'h02;
    irq_clr = 8'hAA;
    settle(8);
    irq_clr = 8'h00;
    check("irq_tied_low", {7'b0, irq_o}, 8'h00);
    gp_raw = 8'h00;
    settle(8);
`endif

    settle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles long.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
